// File: rtl/pds_stim_gen_if.sv
`timescale 1ns/1ps
// Transaction bus between the PDS stimulus engine and its consumer.
// Latency: n/a (wires only).
// Backpressure: consumer holds op_ready low to stall; producer holds fields stable while op_valid.
// Signals:
//   op_valid  - producer has a transaction
//   op_ready  - consumer accepts it this cycle
//   det/off   - per-port detect and off-request vectors
//   prio      - 2-bit priority per port
//   pwr_bdj   - power budget
//   ports_off - global ports-off request
interface pds_stim_gen_if #(
    parameter int NUM_PORTS = 8,
    parameter int BDJ_W     = 8
);
    logic                   op_valid;
    logic                   op_ready;
    logic [NUM_PORTS-1:0]   det;
    logic [NUM_PORTS-1:0]   off;
    logic [2*NUM_PORTS-1:0] prio;
    logic [BDJ_W-1:0]       pwr_bdj;
    logic                   ports_off;

    modport master (
        output op_valid, det, off, prio, pwr_bdj, ports_off,
        input  op_ready
    );

    modport slave (
        input  op_valid, det, off, prio, pwr_bdj, ports_off,
        output op_ready
    );
endinterface

// File: rtl/pds_stim_gen.sv
`timescale 1ns/1ps
// Constrained-random PDS transaction generator driven by a 32-bit Galois LFSR.
// Latency: first op_valid 6 cycles after start; 5-cycle op spacing, 6 across a budget change.
// Backpressure: SEND holds every field and op_valid until op_ready; op_valid is a pure state decode.
//
// Ports:
//   clk, reset_n      - clock, asynchronous active-low reset (aborts any run)
//   start             - begin a run (only honoured in IDLE or DONE)
//   seed_load/seed_in - reload the LFSR (only honoured in IDLE or DONE; 0 selects SEED)
//   op_if             - transaction bus (master side)
//   busy, done        - run in progress / last run finished (done held until next start)
//   op_count          - handshakes in the current or last run
//   sig               - running transaction signature
//
// Optional feature: define PDS_STIM_SIGNATURE_EN to build the signature accumulator;
// without it sig is tied to 0.
module pds_stim_gen #(
    parameter int          NUM_PORTS      = 8,
    parameter int          BDJ_W          = 8,
    parameter int          OUTER_CNT      = 200,
    parameter int          INNER_CNT      = 200,
    parameter logic [31:0] SEED           = 32'hACE1_2024,
    parameter logic [7:0]  PORTS_OFF_CODE = 8'd56
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  seed_load,
    input  logic [31:0]           seed_in,
    pds_stim_gen_if.master        op_if,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           op_count,
    output logic [31:0]           sig
);

    localparam logic [31:0] TAPS       = 32'h8020_0003;
    localparam logic [31:0] INNER_LAST = 32'(INNER_CNT - 1);
    localparam logic [31:0] OUTER_LAST = 32'(OUTER_CNT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BDJ,
        S_GEN,
        S_SEND,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [1:0]             draw_q, draw_d;
    logic [31:0]            lfsr_q, lfsr_d;
    logic [31:0]            inner_q, inner_d;
    logic [31:0]            outer_q, outer_d;
    logic [31:0]            cnt_q, cnt_d;
    logic [NUM_PORTS-1:0]   det_q, det_d;
    logic [NUM_PORTS-1:0]   off_q, off_d;
    logic [2*NUM_PORTS-1:0] prio_q, prio_d;
    logic [BDJ_W-1:0]       bdj_q, bdj_d;
    logic                   poff_q, poff_d;
    logic [31:0]            lfsr_step;

`ifdef PDS_STIM_SIGNATURE_EN
    localparam int PK_W = BDJ_W + 1 + 4 * NUM_PORTS;
    logic [31:0]      sig_q, sig_d;
    // Padding with 32 zero bits above the packed fields makes the low 32 bits
    // the zero-extended or truncated signature input for any parameter set.
    logic [PK_W+31:0] pk_ext;
    assign pk_ext = {32'b0, bdj_q, poff_q, prio_q, off_q, det_q};
`endif

    // Detect/off draw: two low LFSR bits pick all-zeros, all-ones or a raw slice,
    // biasing each corner case to a quarter of the ops.
    function automatic logic [NUM_PORTS-1:0] vec_draw(input logic [31:0] s);
        case (s[1:0])
            2'b00:   vec_draw = '0;
            2'b11:   vec_draw = '1;
            default: vec_draw = s[NUM_PORTS+1:2];
        endcase
    endfunction

    assign lfsr_step = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? TAPS : 32'h0);

    always_comb begin
        state_d = state_q;
        draw_d  = draw_q;
        lfsr_d  = lfsr_q;
        inner_d = inner_q;
        outer_d = outer_q;
        cnt_d   = cnt_q;
        det_d   = det_q;
        off_d   = off_q;
        prio_d  = prio_q;
        bdj_d   = bdj_q;
        poff_d  = poff_q;
`ifdef PDS_STIM_SIGNATURE_EN
        sig_d   = sig_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                // Seed load lands before the run begins, so a same-cycle start uses it.
                if (seed_load) begin
                    lfsr_d = (seed_in == 32'h0) ? SEED : seed_in;
                end
                if (start) begin
                    inner_d = '0;
                    outer_d = '0;
                    cnt_d   = '0;
`ifdef PDS_STIM_SIGNATURE_EN
                    sig_d   = '0;
`endif
                    state_d = S_BDJ;
                end
            end
            S_BDJ: begin
                bdj_d   = lfsr_q[BDJ_W-1:0];
                lfsr_d  = lfsr_step;
                draw_d  = 2'd0;
                state_d = S_GEN;
            end
            S_GEN: begin
                lfsr_d = lfsr_step;
                draw_d = draw_q + 2'd1;
                case (draw_q)
                    2'd0: det_d  = vec_draw(lfsr_q);
                    2'd1: off_d  = vec_draw(lfsr_q);
                    2'd2: prio_d = lfsr_q[2*NUM_PORTS-1:0];
                    default: begin
                        poff_d  = (lfsr_q[7:0] == PORTS_OFF_CODE);
                        state_d = S_SEND;
                    end
                endcase
            end
            S_SEND: begin
                if (op_if.op_ready) begin
                    cnt_d = cnt_q + 32'd1;
`ifdef PDS_STIM_SIGNATURE_EN
                    sig_d = {sig_q[30:0], sig_q[31]} ^ pk_ext[31:0];
`endif
                    if (inner_q < INNER_LAST) begin
                        inner_d = inner_q + 32'd1;
                        state_d = S_GEN;
                    end else if (outer_q < OUTER_LAST) begin
                        inner_d = '0;
                        outer_d = outer_q + 32'd1;
                        state_d = S_BDJ;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            draw_q  <= '0;
            lfsr_q  <= SEED;
            inner_q <= '0;
            outer_q <= '0;
            cnt_q   <= '0;
            det_q   <= '0;
            off_q   <= '0;
            prio_q  <= '0;
            bdj_q   <= '0;
            poff_q  <= 1'b0;
`ifdef PDS_STIM_SIGNATURE_EN
            sig_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            draw_q  <= draw_d;
            lfsr_q  <= lfsr_d;
            inner_q <= inner_d;
            outer_q <= outer_d;
            cnt_q   <= cnt_d;
            det_q   <= det_d;
            off_q   <= off_d;
            prio_q  <= prio_d;
            bdj_q   <= bdj_d;
            poff_q  <= poff_d;
`ifdef PDS_STIM_SIGNATURE_EN
            sig_q   <= sig_d;
`endif
        end
    end

    assign op_if.op_valid  = (state_q == S_SEND);
    assign op_if.det       = det_q;
    assign op_if.off       = off_q;
    assign op_if.prio      = prio_q;
    assign op_if.pwr_bdj   = bdj_q;
    assign op_if.ports_off = poff_q;
    assign busy            = (state_q == S_BDJ) || (state_q == S_GEN) || (state_q == S_SEND);
    assign done            = (state_q == S_DONE);
    assign op_count        = cnt_q;
`ifdef PDS_STIM_SIGNATURE_EN
    assign sig             = sig_q;
`else
    assign sig             = 32'h0;
`endif

endmodule

// File: doc/pds_stim_gen.md
Name: pds_stim_gen

Overview:
- Synthesizable, parametrised constrained-random stimulus engine for the PDS datapath.
- Generates power-budget / detect / off / priority / ports-off transactions from an internal LFSR.
- Issues them over a valid/ready handshake, in nested budget/op loops.
- Used in emulation and in FPGA self-test, where a testbench-only random driver is unavailable.

Parameters:
- NUM_PORTS, 8, number of PoE ports; legal range 1..15.
- BDJ_W, 8, power-budget width; legal range 1..32.
- OUTER_CNT, 200, number of power-budget values per run; must be at least 1.
- INNER_CNT, 200, number of ops issued per budget value; must be at least 1.
- SEED, 32'hACE1_2024, default LFSR seed; must be nonzero.
- PORTS_OFF_CODE, 8'd56, LFSR byte value that raises ports_off.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  begin a run; sampled only in IDLE or DONE
- seed_load  in  1  load seed_in into the LFSR; sampled only in IDLE or DONE
- seed_in  in  32  seed value
- op_valid  out  1  transaction valid
- op_ready  in  1  consumer accepts the transaction
- det  out  NUM_PORTS  detect vector
- off  out  NUM_PORTS  off-request vector
- prio  out  2*NUM_PORTS  2-bit priority per port
- pwr_bdj  out  BDJ_W  power budget
- ports_off  out  1  global ports-off request
- busy  out  1  run in progress
- done  out  1  run complete; held high
- op_count  out  32  number of handshakes in the current or last run
- sig  out  32  transaction signature (see Optional Feature)

Behaviour:
- Reset: all outputs are 0, the LFSR loads SEED, state is IDLE, all counters are 0. Reset takes effect immediately in any state and aborts the run.
- LFSR: 32-bit Galois, taps 32'h8020_0003. It shifts once per cycle in BDJ and GEN only; it holds in all other states.
- seed_load: the LFSR takes seed_in, or SEED if seed_in == 0. If start is high in the same cycle, the seed loads first and the run uses the loaded seed.
- State IDLE/DONE, on start:
  - inner, outer, op_count and sig clear; done clears.
  - Next state is BDJ.
- State BDJ (1 cycle): pwr_bdj <= lfsr[BDJ_W-1:0]. Next state is GEN with draw = 0.
- State GEN (4 cycles, draw 0..3):
  - draw 0, det: lfsr[1:0] == 00 gives all zeros; 11 gives all ones; otherwise lfsr[NUM_PORTS+1:2].
  - draw 1, off: same rule as det.
  - draw 2, prio <= lfsr[2*NUM_PORTS-1:0].
  - draw 3, ports_off <= (lfsr[7:0] == PORTS_OFF_CODE). Next state is SEND.
- State SEND:
  - op_valid is 1. det, off, prio, pwr_bdj and ports_off are stable until op_valid && op_ready.
  - On handshake: op_count increments and op_valid drops in the next cycle.
  - If inner < INNER_CNT-1: inner increments; next state is GEN.
  - Else if outer < OUTER_CNT-1: inner clears, outer increments; next state is BDJ.
  - Else: next state is DONE.
- DONE: done = 1, busy = 0. Field outputs hold their last values. A new start restarts the run.
- busy = 1 in BDJ, GEN and SEND.
- Latency:
  - start is sampled in cycle 0; op_valid is first high in cycle 6.
  - With op_ready held high, ops within one budget are spaced 5 cycles apart. An op that follows a budget change is 6 cycles after the previous one.
- op_valid never depends combinationally on op_ready.
- start and seed_load are ignored while busy.

Optional Feature:
- Macro: PDS_STIM_SIGNATURE_EN.
- Defined: on each handshake, sig <= rotl1(sig) ^ {pwr_bdj, ports_off, prio, off, det}. The packed vector is zero-extended or truncated to 32 bits. sig clears on start and on reset.
- Not defined: sig is constant 0 and no signature logic is present.

Test Plan:
- OUTER_CNT=2, INNER_CNT=3, op_ready=1, start pulse: exactly 6 handshakes; op_count=6. pwr_bdj changes only before handshakes 1 and 4. done rises on the cycle after the 6th handshake; busy falls with it.
- Hold op_ready=0 for 10 cycles while op_valid is high: all fields and op_valid stay constant; op_count is unchanged. One ready cycle gives exactly one handshake.
- seed_load with seed_in=32'h1234_5678, then two runs that each reload the same seed: transaction sequences are identical. seed_in=0 gives the same sequence as SEED.
- Assert reset_n low during GEN of op 3: outputs go to 0 immediately and state is IDLE. The next start reproduces the post-reset sequence from op 1.
- Default parameters, 40000 ops: det==0 and det==8'hFF each about 25% (±2%). ports_off is high about 1/256 of ops. done=1; op_count=40000.
- With PDS_STIM_SIGNATURE_EN: sig matches a bench model computed from the observed handshakes. Without the macro: sig=0 throughout.
